// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking-network output stage.
package snn_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StScan,
        StHold
    } state_e;

    localparam int unsigned DefaultCntW = 8;

    // Class index width; a single line still needs one bit.
    function automatic int unsigned class_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_counter_bank.sv
// Bank of saturating per-line spike counters with synchronous clear and an
// indexed read port for the sequential winner scan.
module spike_counter_bank
    import snn_pkg::*;
#(
    parameter int unsigned N_OUTPUTS = 4,
    parameter int unsigned CNT_W     = DefaultCntW,
    parameter int unsigned CLASS_W   = class_width(N_OUTPUTS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [N_OUTPUTS-1:0] spikes_i,
    input  logic [CLASS_W-1:0]   rd_idx_i,
    output logic [CNT_W-1:0]     rd_cnt_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q [N_OUTPUTS];
    logic [CNT_W-1:0] cnt_d [N_OUTPUTS];

    always_comb begin
        for (int i = 0; i < int'(N_OUTPUTS); i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr_i) begin
                cnt_d[i] = '0;
            end else if (en_i && spikes_i[i] && (cnt_q[i] != CntMax)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(N_OUTPUTS); i++) begin
            if (rst_i) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Out-of-range indices (non power-of-two line counts) read as zero.
    always_comb begin
        rd_cnt_o = '0;
        for (int i = 0; i < int'(N_OUTPUTS); i++) begin
            if (rd_idx_i == CLASS_W'(i)) begin
                rd_cnt_o = cnt_q[i];
            end
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per output line over a fixed window, scans for the line with
// the most spikes and presents class/count/tie over a valid/ready handshake.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int unsigned N_OUTPUTS = 4,
    parameter int unsigned WINDOW    = 64,
    parameter int unsigned CNT_W     = DefaultCntW,
    localparam int unsigned CLASS_W  = class_width(N_OUTPUTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_OUTPUTS-1:0] spikes_in,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [CLASS_W-1:0]   result_class,
    output logic [CNT_W-1:0]     result_count,
    output logic                 result_tie
);

    localparam int unsigned WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0]   WinLast = WIN_W'(WINDOW - 1);
    localparam logic [CLASS_W-1:0] IdxLast = CLASS_W'(N_OUTPUTS - 1);

    state_e             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CLASS_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]   max_q, max_d;
    logic [CLASS_W-1:0] cls_q, cls_d;
    logic               tie_q, tie_d;
    logic [CLASS_W-1:0] res_cls_q, res_cls_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    logic               res_tie_q, res_tie_d;

    logic               cnt_clr;
    logic               cnt_en;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   cand_max;
    logic [CLASS_W-1:0] cand_cls;
    logic               cand_tie;

    spike_counter_bank #(
        .N_OUTPUTS (N_OUTPUTS),
        .CNT_W     (CNT_W),
        .CLASS_W   (CLASS_W)
    ) u_bank (
        .clk_i    (clk),
        .rst_i    (rst),
        .clr_i    (cnt_clr),
        .en_i     (cnt_en),
        .spikes_i (spikes_in),
        .rd_idx_i (idx_q),
        .rd_cnt_o (rd_cnt)
    );

    // Running-max update for the line currently addressed by the scan.
    always_comb begin
        cand_max = max_q;
        cand_cls = cls_q;
        cand_tie = tie_q;
        if (idx_q == '0) begin
            cand_max = rd_cnt;
            cand_cls = '0;
            cand_tie = 1'b0;
        end else if (rd_cnt > max_q) begin
            cand_max = rd_cnt;
            cand_cls = idx_q;
            cand_tie = 1'b0;
        end else if (rd_cnt == max_q) begin
            cand_tie = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        idx_d     = idx_q;
        max_d     = max_q;
        cls_d     = cls_q;
        tie_d     = tie_q;
        res_cls_d = res_cls_q;
        res_cnt_d = res_cnt_q;
        res_tie_d = res_tie_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCount;
                    win_d   = '0;
                    cnt_clr = 1'b1;
                end
            end
            StCount: begin
                cnt_en = 1'b1;
                if (win_q == WinLast) begin
                    state_d = StScan;
                    idx_d   = '0;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            StScan: begin
                max_d = cand_max;
                cls_d = cand_cls;
                tie_d = cand_tie;
                if (idx_q == IdxLast) begin
                    state_d   = StHold;
                    res_cls_d = cand_cls;
                    res_cnt_d = cand_max;
                    res_tie_d = cand_tie;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StHold: begin
                // A start only counts when it coincides with the handshake.
                if (result_ready) begin
                    if (start) begin
                        state_d = StCount;
                        win_d   = '0;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            win_q     <= '0;
            idx_q     <= '0;
            max_q     <= '0;
            cls_q     <= '0;
            tie_q     <= 1'b0;
            res_cls_q <= '0;
            res_cnt_q <= '0;
            res_tie_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            idx_q     <= idx_d;
            max_q     <= max_d;
            cls_q     <= cls_d;
            tie_q     <= tie_d;
            res_cls_q <= res_cls_d;
            res_cnt_q <= res_cnt_d;
            res_tie_q <= res_tie_d;
        end
    end

    assign busy         = (state_q == StCount) || (state_q == StScan);
    assign result_valid = (state_q == StHold);
    assign result_class = res_cls_q;
    assign result_count = res_cnt_q;
    assign result_tie   = res_tie_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench: two decoder configurations (W=16/8-bit and W=20/4-bit
// counters) driven from a shared vector table plus hand-written sequences.
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       st;
    logic       rdy;
    logic [3:0] sp;

    logic       a_start, a_rdy, a_busy, a_valid, a_tie;
    logic [3:0] a_sp;
    logic [1:0] a_class;
    logic [7:0] a_count;
    logic       b_start, b_rdy, b_busy, b_valid, b_tie;
    logic [3:0] b_sp;
    logic [1:0] b_class;
    logic [3:0] b_count;

    logic       o_busy, o_valid, o_tie;
    logic [1:0] o_class;
    logic [7:0] o_count;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    assign a_start = ~sel & st;
    assign a_rdy   = ~sel & rdy;
    assign a_sp    = sel ? 4'b0 : sp;
    assign b_start = sel & st;
    assign b_rdy   = sel & rdy;
    assign b_sp    = sel ? sp : 4'b0;

    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_tie   = sel ? b_tie   : a_tie;
    assign o_class = sel ? b_class : a_class;
    assign o_count = sel ? {4'b0, b_count} : a_count;

    spike_rate_decoder #(
        .N_OUTPUTS (4),
        .WINDOW    (16),
        .CNT_W     (8)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .start        (a_start),
        .spikes_in    (a_sp),
        .busy         (a_busy),
        .result_valid (a_valid),
        .result_ready (a_rdy),
        .result_class (a_class),
        .result_count (a_count),
        .result_tie   (a_tie)
    );

    spike_rate_decoder #(
        .N_OUTPUTS (4),
        .WINDOW    (20),
        .CNT_W     (4)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .start        (b_start),
        .spikes_in    (b_sp),
        .busy         (b_busy),
        .result_valid (b_valid),
        .result_ready (b_rdy),
        .result_class (b_class),
        .result_count (b_count),
        .result_tie   (b_tie)
    );

    typedef struct {
        bit    sel;
        int    c0, c1, c2, c3;
        int    cls, cnt, tie;
        string name;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Line i spikes on the first c_i cycles of the window.
    task automatic run_body(input int c0, input int c1, input int c2, input int c3,
                            input int cls, input int cnt, input int tie, input string tag);
        int w;
        int n;
        w = sel ? 20 : 16;
        for (int cyc = 0; cyc < w; cyc++) begin
            sp = {cyc < c3, cyc < c2, cyc < c1, cyc < c0};
            @(negedge clk);
        end
        sp = 4'b0;
        n = 0;
        while (!o_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, " scan latency"}, n, 4);
        check({tag, " class"}, o_class, cls);
        check({tag, " count"}, o_count, cnt);
        check({tag, " tie"}, o_tie, tie);
        check({tag, " busy in hold"}, o_busy, 0);
    endtask

    task automatic start_pulse();
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
    endtask

    task automatic ack(input string tag);
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        check({tag, " valid after ack"}, o_valid, 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{0, 5, 0, 16, 0, 2, 16, 0, "single_winner"};
        vecs[1] = '{0, 7, 0, 0, 7, 0, 7, 1, "tie_0_3"};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 1, "all_zero"};
        vecs[3] = '{0, 0, 9, 3, 9, 1, 9, 1, "tie_1_3"};
        vecs[4] = '{0, 4, 8, 11, 12, 3, 12, 0, "winner_3"};
        vecs[5] = '{1, 0, 20, 0, 14, 1, 15, 0, "sat_no_tie"};
        vecs[6] = '{1, 0, 20, 0, 18, 1, 15, 1, "sat_tie"};
        vecs[7] = '{1, 20, 0, 15, 0, 0, 15, 1, "sat_exact_tie"};

        // Reset with start asserted and noisy spikes.
        rst = 1'b1;
        sel = 1'b0;
        st  = 1'b1;
        rdy = 1'b0;
        sp  = 4'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sp = 4'($urandom);
        end
        check("reset busy", o_busy, 0);
        check("reset valid", o_valid, 0);
        check("reset class", o_class, 0);
        check("reset count", o_count, 0);
        check("reset tie", o_tie, 0);
        st  = 1'b0;
        sp  = 4'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", o_busy, 0);

        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            @(negedge clk);
            start_pulse();
            check({vecs[i].name, " busy"}, o_busy, 1);
            run_body(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].c3,
                     vecs[i].cls, vecs[i].cnt, vecs[i].tie, vecs[i].name);
            ack(vecs[i].name);
        end

        // Backpressure with start pulses, then a back-to-back window.
        sel = 1'b0;
        @(negedge clk);
        start_pulse();
        run_body(0, 10, 0, 0, 1, 10, 0, "bp_first");
        for (int j = 0; j < 10; j++) begin
            st = j[0];
            @(negedge clk);
            check("bp valid held", o_valid, 1);
            check("bp class held", o_class, 1);
            check("bp count held", o_count, 10);
            check("bp no new window", o_busy, 0);
        end
        st  = 1'b1;
        rdy = 1'b1;
        @(negedge clk);
        st  = 1'b0;
        rdy = 1'b0;
        check("b2b valid drop", o_valid, 0);
        check("b2b busy", o_busy, 1);
        run_body(0, 0, 0, 5, 3, 5, 0, "b2b_second");
        ack("b2b_second");

        // Reset on the 8th COUNT edge aborts with no result.
        start_pulse();
        sp = 4'b0001;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sp  = 4'b0;
        check("midrst busy", o_busy, 0);
        check("midrst valid", o_valid, 0);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_valid) n++;
        end
        check("midrst no result", n, 0);
        start_pulse();
        run_body(2, 0, 3, 0, 2, 3, 0, "after_rst");
        ack("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule
